pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline. It sits beside the decode stage and sequences the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions: load-use hazards between the ID and EX instructions, control redirects from branch/JAL/JALR resolved in EX, and data-memory wait states, with a timeout that locks the pipeline into an error state. Decode-stage rs1/rs2 are already zeroed for formats without them, so a zero index is never a hazard.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive data-memory wait cycles before the error state.
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5 each: source indices from decode.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_MemRead` in 1: EX instruction is a load.
- `ex_rd` in 5: EX destination index.
- `ex_redirect` in 1: taken branch, JAL or JALR resolved in EX.
- `mem_req` in 1: MEM stage asserts MemRead or MemWrite.
- `mem_ready` in 1: data memory completes this cycle.
- `pc_en`, `ifid_en` out 1 each: PC and IF/ID load enables.
- `ifid_flush`, `idex_flush` out 1 each: insert a bubble into IF/ID and ID/EX.
- `exmem_en` out 1: EX/MEM load enable.
- `memwb_bubble` out 1: write a NOP (RegWrite=0) into MEM/WB.
- `mem_timeout` out 1: sticky error flag.
- `state` out 2: current FSM state, for debug.

## Operation
- FSM states (encoding): RUN=0, MEM_WAIT=1, ERROR=2.
- Load-use condition `lu` = id_valid & ex_valid & ex_MemRead & (ex_rd≠0) & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Memory stall condition `mw` = mem_req & ~mem_ready.
- Priority when several conditions hold: ERROR > mw > ex_redirect > lu.
- **Default** (nothing active): pc_en=ifid_en=exmem_en=1; all flush and bubble outputs 0.
- **mw active** (RUN or MEM_WAIT): pc_en=ifid_en=exmem_en=0 and memwb_bubble=1. Every other flush is 0.
- **ex_redirect**: pc_en=1 so the PC loads the target; ifid_flush=idex_flush=1.
- **lu**: pc_en=ifid_en=0 and idex_flush=1, which inserts exactly one bubble. On the next cycle the load is in MEM, so `lu` clears by itself.
- Transitions:
  - RUN→MEM_WAIT on mw; wait_cnt←1.
  - MEM_WAIT stays while mw, with wait_cnt+1 each cycle.
  - MEM_WAIT→RUN the cycle after mem_ready=1.
  - MEM_WAIT→ERROR when mw and wait_cnt==MEM_TIMEOUT.
  - ERROR is terminal until reset.
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits wide, clears on entry to RUN, and saturates without wrapping.
- **ERROR**: pc_en=ifid_en=exmem_en=0, memwb_bubble=1, ifid_flush=idex_flush=1, mem_timeout=1.
- A redirect or load-use that arrives during mw is held, not lost, because EX is frozen. It is acted on in the release cycle.

## Timing
- All enable, flush and bubble outputs are combinational from the inputs and the registered state, so they take effect at the same clock edge. Latency is 0 cycles.
- State, wait_cnt and counters update on the rising clk edge.
- Reset values while rst=0, applied immediately (asynchronously):
  - state=RUN, wait_cnt=0, mem_timeout=0.
  - pc_en=ifid_en=exmem_en=0.
  - ifid_flush=idex_flush=memwb_bubble=1.
  - All counters 0.
- A reset mid-MEM_WAIT or mid-ERROR discards the wait. After release, the first cycle is RUN with default outputs.
- mem_ready=1 in the first cycle of mem_req gives no stall and no state change.

## Configuration
- Macro `PIPE_CTRL_PERF_EN`.
- When defined, four CNT_W-bit wrap-around counters are added, each incrementing once per cycle under its condition:
  - `perf_lu_stalls`: cycles where `lu` is acted on.
  - `perf_mem_stalls`: cycles where mw is true.
  - `perf_flushes`: cycles where ex_redirect is acted on.
  - `perf_cycles`: every cycle outside reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

## Structure
- Package `rv_pipe_pkg`: state typedef (RUN/MEM_WAIT/ERROR), the 2-bit state width and the x0 index constant.
- Sub-module `load_use_detect`: purely combinational generation of `lu` from the ID/EX fields. The controller instantiates it once.

## Test plan
- ex_valid=1, ex_MemRead=1, ex_rd=5, id_valid=1, id_rs2=5 → for exactly 1 cycle pc_en=0, ifid_en=0, idex_flush=1, then default outputs; perf_lu_stalls=1.
- ex_MemRead=1, ex_rd=0, id_rs1=0 → no stall; pc_en=1.
- ex_redirect=1 for 1 cycle → pc_en=1, ifid_flush=idex_flush=1 in that cycle; perf_flushes=1.
- mem_req=1 with mem_ready=0 for 3 cycles then 1 → 3 frozen cycles with memwb_bubble=1 and state=MEM_WAIT; release in the 4th cycle; state=RUN on the next edge. Same stimulus with ex_redirect=1 throughout → flush fires only in the 4th cycle.
- MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 → state=ERROR after the 5th stalled edge, mem_timeout=1, and it stays there with mem_ready later 1 until rst=0.
- rst pulled low during MEM_WAIT → outputs take reset values immediately; after release, state=RUN and mem_timeout=0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared state encoding and constants for the RV32I pipeline hazard controller.
package rv_pipe_pkg;
    localparam int STATE_W = 2;
    localparam logic [4:0] X0 = 5'd0;
    typedef enum logic [STATE_W-1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
    import rv_pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       lu
);
    assign lu = id_valid & ex_valid & ex_mem_read & (ex_rd != X0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for load-use, redirects and data-memory waits.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_valid,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_timeout,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_mem_stalls,
    output logic [CNT_W-1:0] perf_flushes,
    output logic [CNT_W-1:0] perf_cycles,
`endif
    output logic [STATE_W-1:0] state
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    state_t cur, nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic lu, mw;
    assign mw = mem_req & ~mem_ready;
    load_use_detect u_lu (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (ex_valid),
        .ex_mem_read(ex_MemRead),
        .ex_rd      (ex_rd),
        .lu         (lu)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= RUN;
            wait_cnt <= '0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
        end
    end
    always_comb begin
        nxt      = cur;
        wait_nxt = wait_cnt;
        if (cur != ERROR) begin
            if (!mw) begin
                nxt      = RUN;
                wait_nxt = '0;
            end else if (cur == MEM_WAIT && wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                nxt = ERROR;
            end else begin
                nxt      = MEM_WAIT;
                wait_nxt = (cur == RUN) ? WAIT_W'(1) : ((&wait_cnt) ? wait_cnt : wait_cnt + 1'b1);
            end
        end
    end
    // Hazards held during a memory stall stay visible on the inputs because EX is frozen.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst || cur == ERROR || mw) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            ifid_flush   = !rst || cur == ERROR;
            idex_flush   = !rst || cur == ERROR;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end
    assign mem_timeout = (cur == ERROR);
    assign state       = cur;
`ifdef PIPE_CTRL_PERF_EN
    logic live;
    assign live = (cur != ERROR) & ~mw;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_stalls  <= '0;
            perf_mem_stalls <= '0;
            perf_flushes    <= '0;
            perf_cycles     <= '0;
        end else begin
            perf_lu_stalls  <= perf_lu_stalls + CNT_W'(live & ~ex_redirect & lu);
            perf_mem_stalls <= perf_mem_stalls + CNT_W'(mw);
            perf_flushes    <= perf_flushes + CNT_W'(live & ex_redirect);
            perf_cycles     <= perf_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks of the hazard controller against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int T = 4;
    localparam int CW = 32;
    logic clk = 0, rst = 0;
    logic id_valid = 0, ex_valid = 0, ex_MemRead = 0, ex_redirect = 0, mem_req = 0, mem_ready = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_timeout;
    logic [1:0] state;
`ifdef PIPE_CTRL_PERF_EN
    logic [CW-1:0] perf_lu_stalls, perf_mem_stalls, perf_flushes, perf_cycles;
`endif
    int checks = 0, passed = 0;
    int streak = 0;
    bit errored = 0;
    int m_lu = 0, m_mem = 0, m_fl = 0, m_cyc = 0;
    wire [8:0] obs = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_timeout, state};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
`ifdef PIPE_CTRL_PERF_EN
        .perf_lu_stalls(perf_lu_stalls), .perf_mem_stalls(perf_mem_stalls),
        .perf_flushes(perf_flushes), .perf_cycles(perf_cycles),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit hazard_lu();
        return id_valid && ex_valid && ex_MemRead && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    endfunction

    // Expected {pc_en,ifid_en,ifid_flush,idex_flush,exmem_en,memwb_bubble,mem_timeout,state}.
    function automatic logic [8:0] exp_out();
        bit mw = mem_req && !mem_ready;
        logic [1:0] st = (streak > 0) ? 2'd1 : 2'd0;
        if (!rst) return {7'b0011010, 2'd0};
        if (errored) return {7'b0011011, 2'd2};
        if (mw) return {7'b0000010, st};
        if (ex_redirect) return {7'b1111100, st};
        if (hazard_lu()) return {7'b0001100, st};
        return {7'b1100100, st};
    endfunction

    task automatic model_step();
        bit mw = mem_req && !mem_ready;
        if (!rst) begin
            streak = 0; errored = 0; m_lu = 0; m_mem = 0; m_fl = 0; m_cyc = 0;
        end else begin
            m_cyc++;
            if (mw) m_mem++;
            if (!errored && !mw && ex_redirect) m_fl++;
            if (!errored && !mw && !ex_redirect && hazard_lu()) m_lu++;
            if (!errored) begin
                if (!mw) streak = 0;
                else if (streak == T) errored = 1;
                else streak++;
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] r1, input logic [4:0] r2, input logic ev,
                         input logic mr, input logic [4:0] rd, input logic rdr, input logic mq, input logic my);
        id_valid = iv; id_rs1 = r1; id_rs2 = r2; ex_valid = ev; ex_MemRead = mr; ex_rd = rd;
        ex_redirect = rdr; mem_req = mq; mem_ready = my;
    endtask

    task automatic do_reset();
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); model_step(); #1;
        rst = 1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs !== {7'b0011010, 2'd0}) $display("FAIL reset_hold: got %b want %b", obs, {7'b0011010, 2'd0});
        else passed++;
        do_reset();
        @(negedge clk);
        checks++;
        if (obs !== exp_out()) $display("FAIL reset_release: got %b want %b", obs, exp_out());
        else passed++;
        @(posedge clk); model_step(); #1;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(1, 0, 5, 1, 1, 5, 0, 0, 0);
            else drive(1, 0, 5, 1, 0, 5, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_out()) $display("FAIL load_use c%0d: got %b want %b", i, obs, exp_out());
            else passed++;
            @(posedge clk); model_step(); #1;
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (perf_lu_stalls !== CW'(m_lu)) $display("FAIL perf_lu: got %0d want %0d", perf_lu_stalls, m_lu);
        else passed++;
`endif
    endtask

    task automatic test_x0();
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (obs !== exp_out() || pc_en !== 1'b1) $display("FAIL x0_no_stall: got %b want %b", obs, exp_out());
        else passed++;
        @(posedge clk); model_step(); #1;
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 2; i++) begin
            drive(1, 3, 3, 1, 1, 3, i == 0, 0, 0);
            @(negedge clk);
            checks++;
            if (obs !== exp_out()) $display("FAIL redirect c%0d: got %b want %b", i, obs, exp_out());
            else passed++;
            @(posedge clk); model_step(); #1;
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (perf_flushes !== CW'(m_fl)) $display("FAIL perf_flush: got %0d want %0d", perf_flushes, m_fl);
        else passed++;
`endif
    endtask

    task automatic test_mem_wait();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) begin
                drive(0, 0, 0, 0, 0, 0, (r == 1) && (i < 4), i < 4, i >= 3);
                @(negedge clk);
                checks++;
                if (obs !== exp_out()) $display("FAIL mem_wait r%0d c%0d: got %b want %b", r, i, obs, exp_out());
                else passed++;
                @(posedge clk); model_step(); #1;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checks++;
        if (obs !== exp_out()) $display("FAIL mem_ready_first: got %b want %b", obs, exp_out());
        else passed++;
        @(posedge clk); model_step(); #1;
        checks++;
        if (state !== 2'd0) $display("FAIL mem_ready_first_state: got %0d want 0", state);
        else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, i >= 6);
            @(negedge clk);
            checks++;
            if (obs !== exp_out()) $display("FAIL timeout c%0d: got %b want %b", i, obs, exp_out());
            else passed++;
            @(posedge clk); model_step(); #1;
        end
        checks++;
        if (state !== 2'd2 || mem_timeout !== 1'b1) $display("FAIL timeout_sticky: got st=%0d to=%b want st=2 to=1", state, mem_timeout);
        else passed++;
        do_reset();
        #1;
        checks++;
        if (state !== 2'd0 || mem_timeout !== 1'b0) $display("FAIL timeout_clear: got st=%0d to=%b want st=0 to=0", state, mem_timeout);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            @(posedge clk); model_step(); #1;
        end
        rst = 0;
        #1;
        checks++;
        if (obs !== {7'b0011010, 2'd0}) $display("FAIL reset_async: got %b want %b", obs, {7'b0011010, 2'd0});
        else passed++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); model_step(); #1;
        rst = 1;
        @(negedge clk);
        checks++;
        if (obs !== exp_out() || obs !== {7'b1100100, 2'd0}) $display("FAIL reset_after_wait: got %b want %b", obs, exp_out());
        else passed++;
        @(posedge clk); model_step(); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(1), 5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1),
                  $urandom_range(1), 5'($urandom_range(3)), $urandom_range(4) == 0,
                  $urandom_range(2) == 0, $urandom_range(3) != 0);
            rst = ($urandom_range(39) != 0);
            #1;
            @(negedge clk);
            checks++;
            if (obs !== exp_out()) $display("FAIL random c%0d: got %b want %b", i, obs, exp_out());
            else passed++;
            @(posedge clk); model_step(); #1;
            rst = 1;
        end
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if ({perf_lu_stalls, perf_mem_stalls, perf_flushes, perf_cycles} !== {CW'(m_lu), CW'(m_mem), CW'(m_fl), CW'(m_cyc)})
            $display("FAIL perf_random: got %0d %0d %0d %0d want %0d %0d %0d %0d", perf_lu_stalls,
                     perf_mem_stalls, perf_flushes, perf_cycles, m_lu, m_mem, m_fl, m_cyc);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
